// File: rtl/spi_pwm_multichannel.sv
// SPI mode-0 slave (16-bit frames) driving a register file of per-channel PWM generators.
// Each channel has a prescaler and an 8-bit period counter, with duty/divider updates applied at the period boundary.
module spi_pwm_multichannel #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SCLK,
  input  logic              COPI,
  input  logic              nCS,
  output logic              CIPO,
  output logic [NUM_CH-1:0] pwm_out
);

  typedef enum logic {ST_IDLE, ST_FRAME} spi_state_t;

  localparam logic [15:0] CH_MASK = (NUM_CH >= 16) ? 16'hFFFF
                                                   : 16'((32'd1 << NUM_CH) - 32'd1);

  // One extra flop on SCLK/nCS holds the previous synchronized sample for edge detection.
  logic [SYNC_STAGES:0]   r_sclk_q;
  logic [SYNC_STAGES:0]   r_ncs_q;
  logic [SYNC_STAGES-1:0] r_copi_q;

  logic w_sclk_rise, w_sclk_fall, w_ncs_rise, w_ncs_fall, w_ncs_s, w_copi_s;

  assign w_sclk_rise = r_sclk_q[SYNC_STAGES-1] & ~r_sclk_q[SYNC_STAGES];
  assign w_sclk_fall = ~r_sclk_q[SYNC_STAGES-1] & r_sclk_q[SYNC_STAGES];
  assign w_ncs_rise  = r_ncs_q[SYNC_STAGES-1] & ~r_ncs_q[SYNC_STAGES];
  assign w_ncs_fall  = ~r_ncs_q[SYNC_STAGES-1] & r_ncs_q[SYNC_STAGES];
  assign w_ncs_s     = r_ncs_q[SYNC_STAGES-1];
  assign w_copi_s    = r_copi_q[SYNC_STAGES-1];

  spi_state_t r_state, w_state_nxt;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_shift_in;
  logic [7:0]  r_shift_out;
  logic        r_cipo;

  logic [15:0] r_en;
  logic [15:0] r_pol;
  logic [7:0]  r_duty [NUM_CH];
  logic [7:0]  r_div  [NUM_CH];

  logic        w_commit, w_load_rd;
  logic [6:0]  w_wr_addr, w_rd_addr;
  logic [7:0]  w_wr_data, w_rd_data;

  assign w_wr_addr = r_shift_in[14:8];
  assign w_wr_data = r_shift_in[7:0];
  // At the 8th rising edge the address LSB is still on the synchronized COPI line.
  assign w_rd_addr = {r_shift_in[5:0], w_copi_s};

  // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_load_rd   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ncs_fall) w_state_nxt = ST_FRAME;
      end
      ST_FRAME: begin
        if (w_ncs_rise) begin
          w_state_nxt = ST_IDLE;
          w_commit    = (r_bit_cnt == 5'd16) && r_shift_in[15];
        end
        w_load_rd = w_sclk_rise && (r_bit_cnt == 5'd7) && !r_shift_in[6];
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (w_rd_addr)
      7'h00:   w_rd_data = r_en[7:0];
      7'h01:   w_rd_data = r_en[15:8];
      7'h02:   w_rd_data = r_pol[7:0];
      7'h03:   w_rd_data = r_pol[15:8];
      7'h7F:   w_rd_data = 8'(NUM_CH);
      default: w_rd_data = 8'h00;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_rd_addr == 7'(16 + i)) w_rd_data = r_duty[i];
      if (w_rd_addr == 7'(32 + i)) w_rd_data = r_div[i];
    end
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_q    <= '0;
      r_ncs_q     <= '0;
      r_copi_q    <= '0;
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_cipo      <= 1'b0;
    end else begin
      r_sclk_q <= {r_sclk_q[SYNC_STAGES-1:0], SCLK};
      r_ncs_q  <= {r_ncs_q[SYNC_STAGES-1:0], nCS};
      r_copi_q <= {r_copi_q[SYNC_STAGES-2:0], COPI};
      if (w_ncs_fall) begin
        r_bit_cnt   <= '0;
        r_shift_in  <= '0;
        r_shift_out <= '0;
        r_cipo      <= 1'b0;
      end else if (r_state == ST_FRAME) begin
        if (w_sclk_rise) begin
          r_shift_in <= {r_shift_in[14:0], w_copi_s};
          if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
          if (w_load_rd) r_shift_out <= w_rd_data;
        end
        if (w_sclk_fall && (r_bit_cnt >= 5'd8)) begin
          r_cipo      <= r_shift_out[7];
          r_shift_out <= {r_shift_out[6:0], 1'b0};
        end
      end
      if (w_ncs_s) r_cipo <= 1'b0;
    end
  end

  assign CIPO = r_cipo & ~w_ncs_s;

  // NOTE: the duty/divider arrays are cleared on reset because a known power-up output is required; plain RAM-style storage would skip this.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en  <= '0;
      r_pol <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty[i] <= '0;
        r_div[i]  <= '0;
      end
    end else if (w_commit) begin
      case (w_wr_addr)
        7'h00:   r_en[7:0]   <= w_wr_data & CH_MASK[7:0];
        7'h01:   r_en[15:8]  <= w_wr_data & CH_MASK[15:8];
        7'h02:   r_pol[7:0]  <= w_wr_data & CH_MASK[7:0];
        7'h03:   r_pol[15:8] <= w_wr_data & CH_MASK[15:8];
        default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_addr == 7'(16 + i)) r_duty[i] <= w_wr_data;
        if (w_wr_addr == 7'(32 + i)) r_div[i]  <= w_wr_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [7:0] r_presc, r_period, r_duty_act, r_div_act;
    logic       r_pwm;
    logic       w_raw;

    assign w_raw      = r_period < r_duty_act;
    assign pwm_out[g] = r_pwm;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_presc    <= '0;
        r_period   <= '0;
        r_duty_act <= '0;
        r_div_act  <= '0;
        r_pwm      <= 1'b0;
      end else begin
        r_pwm <= r_en[g] ? (w_raw ^ r_pol[g]) : r_pol[g];
        if (!r_en[g]) begin
          r_presc    <= '0;
          r_period   <= '0;
          r_duty_act <= r_duty[g];
          r_div_act  <= r_div[g];
        end else if (r_presc == r_div_act) begin
          r_presc <= '0;
          // Shadows load only at the period wrap so a running period is never cut short.
          if (r_period == 8'd254) begin
            r_period   <= '0;
            r_duty_act <= r_duty[g];
            r_div_act  <= r_div[g];
          end else begin
            r_period <= r_period + 8'd1;
          end
        end else begin
          r_presc <= r_presc + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_pwm_multichannel.sv
// Directed bench for spi_pwm_multichannel: SPI reads and PWM pulse widths are checked
// against hand-computed values through queues drained by independent monitors.
module tb_spi_pwm_multichannel;

  localparam int NUM_CH = 8;
  localparam int HALF   = 4;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              SCLK  = 1'b0;
  logic              COPI  = 1'b0;
  logic              nCS   = 1'b1;
  logic              CIPO;
  logic [NUM_CH-1:0] pwm_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [7:0] data;
  } rd_exp_t;

  typedef struct {
    string name;
    logic  lvl;
    int    width;
  } pw_exp_t;

  rd_exp_t q_rd[$];
  pw_exp_t q_pw[$];

  always #5 clk = ~clk;

  spi_pwm_multichannel #(.NUM_CH(NUM_CH), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SCLK    (SCLK),
    .COPI    (COPI),
    .nCS     (nCS),
    .CIPO    (CIPO),
    .pwm_out (pwm_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_rd(input string name, input logic [7:0] data);
    rd_exp_t e;
    e.name = name;
    e.data = data;
    q_rd.push_back(e);
  endtask

  task automatic push_pw(input string name, input logic lvl, input int width);
    pw_exp_t e;
    e.name  = name;
    e.lvl   = lvl;
    e.width = width;
    q_pw.push_back(e);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the low nbits of word MSB first; rst_at >= 0 pulses reset before that bit index.
  task automatic spi_xfer(input logic [16:0] word, input int nbits, input int rst_at);
    nCS = 1'b0;
    wait_clks(HALF);
    for (int k = 0; k < nbits; k++) begin
      if (k == rst_at) begin
        rst_n = 1'b0;
        wait_clks(3);
        check("rst_mid_pwm", 32'(pwm_out), 32'h0);
        check("rst_mid_cipo", 32'(CIPO), 32'h0);
        rst_n = 1'b1;
        wait_clks(2);
      end
      COPI = word[nbits-1-k];
      wait_clks(HALF);
      SCLK = 1'b1;
      wait_clks(HALF);
      SCLK = 1'b0;
    end
    wait_clks(HALF);
    nCS  = 1'b1;
    COPI = 1'b0;
    wait_clks(3 * HALF);
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    spi_xfer({1'b0, 1'b1, addr, data}, 16, -1);
  endtask

  task automatic spi_read(input string name, input logic [6:0] addr, input logic [7:0] exp);
    push_rd(name, exp);
    spi_xfer({1'b0, 1'b0, addr, 8'h00}, 16, -1);
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = budget;
    while (q_pw.size() > 0 && b > 0) begin
      wait_clks(1);
      b--;
    end
  endtask

  task automatic wait_rise0(input int budget, output logic found);
    logic p;
    int   b;
    p     = pwm_out[0];
    b     = budget;
    found = 1'b0;
    while (b > 0 && !found) begin
      @(negedge clk);
      if (!p && pwm_out[0]) found = 1'b1;
      p = pwm_out[0];
      b--;
    end
  endtask

  // Bus monitor: decodes each frame and scores completed 16-bit reads.
  initial begin
    logic [15:0] cmd, rd;
    int          n;
    rd_exp_t     e;
    forever begin
      @(negedge nCS);
      n   = 0;
      cmd = '0;
      rd  = '0;
      while (nCS == 1'b0) begin
        @(posedge SCLK or posedge nCS);
        if (nCS == 1'b0) begin
          cmd = {cmd[14:0], COPI};
          rd  = {rd[14:0], CIPO};
          n++;
        end
      end
      if (n == 16 && !cmd[15]) begin
        if (q_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read: got %0h, expected no read", rd[7:0]);
        end else begin
          e = q_rd.pop_front();
          check({e.name, "_hdr"}, 32'(rd[15:8]), 32'h0);
          check(e.name, 32'(rd[7:0]), 32'(e.data));
        end
      end
    end
  end

  // Pulse monitor: measures channel-0 run lengths and scores them against queued widths.
  initial begin
    logic    prev;
    int      len;
    pw_exp_t e;
    prev = 1'b0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (pwm_out[0] === prev) begin
        len++;
      end else begin
        if (q_pw.size() > 0 && q_pw[0].lvl === prev) begin
          e = q_pw.pop_front();
          check(e.name, 32'(len), 32'(e.width));
        end
        prev = pwm_out[0];
        len  = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    int   hi;

    rst_n = 1'b0;
    wait_clks(5);
    check("reset_pwm", 32'(pwm_out), 32'h0);
    check("reset_cipo", 32'(CIPO), 32'h0);
    rst_n = 1'b1;
    wait_clks(10);

    spi_read("id", 7'h7F, 8'h08);

    // Channel 0 at 50%: 128 high, 127 low per 255-clk period.
    spi_write(7'h10, 8'h80);
    spi_write(7'h20, 8'h00);
    push_pw("hi128_a", 1'b1, 128);
    push_pw("lo127", 1'b0, 127);
    push_pw("hi128_b", 1'b1, 128);
    spi_write(7'h00, 8'h01);
    wait_drain(1000);
    spi_read("duty0", 7'h10, 8'h80);
    spi_read("en_lo", 7'h00, 8'h01);

    spi_write(7'h05, 8'hAA);
    spi_read("unmapped", 7'h05, 8'h00);
    spi_write(7'h18, 8'h55);
    spi_read("duty_ch8", 7'h18, 8'h00);
    spi_write(7'h7F, 8'h33);
    spi_read("id_ro", 7'h7F, 8'h08);
    spi_write(7'h01, 8'hFF);
    spi_read("en_hi", 7'h01, 8'h00);

    // Duty change mid-period takes effect only at the next period.
    spi_write(7'h10, 8'h40);
    wait_rise0(600, found);
    check("ch0_rise", 32'(found), 32'h1);
    push_pw("hi64_cur", 1'b1, 64);
    push_pw("hi192_next", 1'b1, 192);
    spi_write(7'h10, 8'hC0);
    wait_drain(1000);

    // Short and long frames must not commit.
    spi_xfer(17'h0407F, 15, -1);
    spi_read("en_15bit", 7'h00, 8'h01);
    spi_xfer(17'h180FF, 17, -1);
    spi_read("en_17bit", 7'h00, 8'h01);

    // Polarity on a disabled channel, then full duty inverted to constant low.
    spi_write(7'h02, 8'h02);
    check("pol1_disabled", 32'(pwm_out[1]), 32'h1);
    spi_write(7'h11, 8'hFF);
    spi_write(7'h00, 8'h03);
    hi = 0;
    repeat (600) begin
      @(negedge clk);
      if (pwm_out[1]) hi++;
    end
    check("pol1_ff_high_cycles", 32'(hi), 32'h0);

    // Reset during a write frame: nothing commits, next frame works.
    spi_xfer({1'b0, 1'b1, 7'h10, 8'h11}, 16, 10);
    check("abort_pwm", 32'(pwm_out), 32'h0);
    spi_read("abort_duty", 7'h10, 8'h00);
    spi_read("abort_en", 7'h00, 8'h00);
    spi_write(7'h10, 8'h22);
    spi_read("after_abort", 7'h10, 8'h22);
    wait_clks(10);

    while (q_rd.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: got no read, expected %0h", q_rd[0].name, q_rd[0].data);
      void'(q_rd.pop_front());
    end
    while (q_pw.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: got no pulse, expected width %0d", q_pw[0].name, q_pw[0].width);
      void'(q_pw.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
